// File: rtl/io_bus_sequencer.sv
// Two-requester round-robin sequencer for the shared 8-device I/O decode bus.
// Runs address setup, waits on per-device ready with timeout, and acks completion.
module io_bus_sequencer #(
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT   = 16,
  parameter int PARK_DEV  = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [2:0]  dev0,
  input  logic [2:0]  dev1,
  input  logic [1:0]  reg0,
  input  logic [1:0]  reg1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [2:0]  io_dev_sel,
  output logic [1:0]  io_reg_sel,
  output logic        io_we,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  input  logic [7:0]  io_ready
);

  localparam logic [7:0] SETUP_N = 8'(SETUP_CYC);
  localparam logic [7:0] TMO_N   = 8'(TIMEOUT);
  localparam logic [2:0] PARK    = 3'(PARK_DEV);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [2:0]  dev_q, dev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic [2:0]  sel_q, sel_d;
  logic [1:0]  rsel_q, rsel_d;
  logic        we_q, we_d;
  logic [15:0] wd_q, wd_d;
  logic        win;
  logic        fin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      dev_q   <= 3'd0;
      cnt_q   <= 8'd0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      sel_q   <= PARK;
      rsel_q  <= 2'd0;
      we_q    <= 1'b0;
      wd_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      dev_q   <= dev_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      rsel_q  <= rsel_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    dev_d   = dev_q;
    cnt_d   = cnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    rsel_d  = rsel_q;
    we_d    = we_q;
    wd_d    = wd_q;
    fin     = 1'b0;
    // contention goes to whoever was not served last
    win     = (req0 && req1) ? ~last_q : req1;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = SETUP;
          gnt_d   = win;
          last_d  = win;
          wr_d    = win ? wr1 : wr0;
          dev_d   = win ? dev1 : dev0;
          cnt_d   = 8'd1;
          sel_d   = win ? dev1 : dev0;
          rsel_d  = win ? reg1 : reg0;
          wd_d    = win ? wdata1 : wdata0;
          we_d    = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q >= SETUP_N) begin
          state_d = ACCESS;
          cnt_d   = 8'd1;
          we_d    = wr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACCESS: begin
        // ready takes priority over an expiring timeout
        if (io_ready[dev_q]) begin
          fin   = 1'b1;
          err_d = 1'b0;
          if (!wr_q) rdata_d = io_rdata;
        end else if (cnt_q >= TMO_N) begin
          fin     = 1'b1;
          err_d   = 1'b1;
          rdata_d = 16'h0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (fin) begin
          state_d = DONE;
          we_d    = 1'b0;
          sel_d   = PARK;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        sel_d   = PARK;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign io_dev_sel = sel_q;
  assign io_reg_sel = rsel_q;
  assign io_we      = we_q;
  assign io_wdata   = wd_q;

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Directed bench for io_bus_sequencer: per-cycle vector table for single
// transactions, hand sequences for arbitration, timeout, wait states and reset.
module tb_io_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, wr0, wr1;
  logic [2:0]  dev0, dev1;
  logic [1:0]  reg0, reg1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, err, busy, io_we;
  logic [15:0] rdata, io_wdata, io_rdata;
  logic [2:0]  io_dev_sel;
  logic [1:0]  io_reg_sel;
  logic [7:0]  io_ready;

  io_bus_sequencer #(
    .SETUP_CYC(1),
    .TIMEOUT(16),
    .PARK_DEV(7)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .dev0(dev0), .dev1(dev1), .reg0(reg0), .reg1(reg1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
    .io_dev_sel(io_dev_sel), .io_reg_sel(io_reg_sel),
    .io_we(io_we), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r0, r1, w0, w1;
    logic [2:0] d0, d1;
    logic [1:0] g0, g1;
    logic [15:0] wd0, wd1;
    logic [7:0] rdy;
    logic [15:0] rd;
    logic a0, a1, er;
    logic [15:0] rdat;
    logic bsy;
    logic [2:0] sel;
    logic [1:0] rsel;
    logic we;
    logic [15:0] wd;
  } vec_t;

  vec_t tbl[8];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [47:0] act,
                     input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return 48'({ack0, ack1, err, rdata, busy,
                io_dev_sel, io_reg_sel, io_we, io_wdata});
  endfunction

  function automatic logic [47:0] pk(input logic a0, input logic a1,
      input logic er, input logic [15:0] rd, input logic bsy,
      input logic [2:0] sel, input logic [1:0] rsel, input logic we,
      input logic [15:0] wd);
    return 48'({a0, a1, er, rd, bsy, sel, rsel, we, wd});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string nm, input int ready_at,
                         input logic [7:0] mask, output int ack_e,
                         output int we_cnt, output logic who);
    ack_e = 0;
    we_cnt = 0;
    who = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (io_we) we_cnt++;
      if (ack0 || ack1) begin
        ack_e = e;
        who = ack1;
        req0 = 1'b0;
        req1 = 1'b0;
        break;
      end
      if (e == ready_at) io_ready = mask;
    end
    io_ready = 8'h00;
    step();
    chk({nm, "_pulse"}, 48'({ack0, ack1}), 48'd0);
  endtask

  int ack_e, we_cnt, nack, last_c, overlap, exp_who, nres;
  logic who;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 2'd1, 2'd0,
               16'h0BAD, 16'h0000, 8'h04, 16'hA5C3,
               1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 2'd1, 1'b0, 16'h0BAD};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 2'd1, 2'd0,
               16'h0BAD, 16'h0000, 8'h04, 16'hA5C3,
               1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 2'd1, 1'b0, 16'h0BAD};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 2'd1, 2'd0,
               16'h0BAD, 16'h0000, 8'h04, 16'hA5C3,
               1'b1, 1'b0, 1'b0, 16'hA5C3, 1'b1, 3'd7, 2'd1, 1'b0, 16'h0BAD};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 2'd0,
               16'h0000, 16'h0000, 8'h00, 16'h0000,
               1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b0, 3'd7, 2'd1, 1'b0, 16'h0BAD};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 2'd0, 2'd2,
               16'h0000, 16'h1234, 8'h20, 16'h7777,
               1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b1, 3'd5, 2'd2, 1'b0, 16'h1234};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 2'd0, 2'd2,
               16'h0000, 16'h1234, 8'h20, 16'h7777,
               1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b1, 3'd5, 2'd2, 1'b1, 16'h1234};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 2'd0, 2'd2,
               16'h0000, 16'h1234, 8'h20, 16'h7777,
               1'b0, 1'b1, 1'b0, 16'hA5C3, 1'b1, 3'd7, 2'd2, 1'b0, 16'h1234};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 2'd0,
               16'h0000, 16'h0000, 8'h00, 16'h0000,
               1'b0, 1'b0, 1'b0, 16'hA5C3, 1'b0, 3'd7, 2'd2, 1'b0, 16'h1234};

    reset_n = 1'b0;
    {req0, req1, wr0, wr1} = 4'b0;
    dev0 = 3'd0; dev1 = 3'd0; reg0 = 2'd0; reg1 = 2'd0;
    wdata0 = 16'h0; wdata1 = 16'h0;
    io_rdata = 16'h0; io_ready = 8'h00;
    step();
    step();
    chk("reset_vals", outs(), pk(0, 0, 0, 16'h0, 0, 3'd7, 2'd0, 0, 16'h0));
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      wr0 = tbl[i].w0; wr1 = tbl[i].w1;
      dev0 = tbl[i].d0; dev1 = tbl[i].d1;
      reg0 = tbl[i].g0; reg1 = tbl[i].g1;
      wdata0 = tbl[i].wd0; wdata1 = tbl[i].wd1;
      io_ready = tbl[i].rdy; io_rdata = tbl[i].rd;
      step();
      chk($sformatf("row%0d", i), outs(),
          pk(tbl[i].a0, tbl[i].a1, tbl[i].er, tbl[i].rdat, tbl[i].bsy,
             tbl[i].sel, tbl[i].rsel, tbl[i].we, tbl[i].wd));
    end

    // both requesters held: grants alternate starting with 0
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    dev0 = 3'd1; dev1 = 3'd6; io_ready = 8'hFF; io_rdata = 16'h5555;
    nack = 0; last_c = 0; overlap = 0; exp_who = 0;
    for (int c = 1; c <= 40 && nack < 4; c++) begin
      step();
      if (ack0 && ack1) overlap++;
      if (ack0 || ack1) begin
        chk("t4_who", 48'(ack1), 48'(exp_who));
        if (nack > 0) chk("t4_gap", 48'(c - last_c), 48'd4);
        last_c = c;
        exp_who ^= 1;
        nack++;
        if (nack == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk("t4_count", 48'(nack), 48'd4);
    chk("t4_overlap", 48'(overlap), 48'd0);
    io_ready = 8'h00;
    step();

    req0 = 1'b1; wr0 = 1'b0; dev0 = 3'd3;
    run_txn("t5a", 0, 8'h00, ack_e, we_cnt, who);
    chk("t5a_lat", 48'(ack_e), 48'd18);
    chk("t5a_err", 48'(err), 48'd1);
    chk("t5a_rdata", 48'(rdata), 48'h0);

    req0 = 1'b1; io_rdata = 16'hBEEF;
    run_txn("t5b", 17, 8'h08, ack_e, we_cnt, who);
    chk("t5b_lat", 48'(ack_e), 48'd18);
    chk("t5b_err", 48'(err), 48'd0);
    chk("t5b_rdata", 48'(rdata), 48'hBEEF);

    req1 = 1'b1; wr1 = 1'b1; dev1 = 3'd4; wdata1 = 16'hCAFE;
    run_txn("t6", 6, 8'h10, ack_e, we_cnt, who);
    chk("t6_lat", 48'(ack_e), 48'd7);
    chk("t6_we_cycles", 48'(we_cnt), 48'd5);
    chk("t6_who", 48'(who), 48'd1);
    chk("t6_err", 48'(err), 48'd0);

    req0 = 1'b1; wr0 = 1'b1; dev0 = 3'd2; wdata0 = 16'h4321;
    io_ready = 8'h00;
    step();
    step();
    chk("t1_we_pre", 48'(io_we), 48'd1);
    #2 reset_n = 1'b0;
    #1 chk("t1_reset", outs(), pk(0, 0, 0, 16'h0, 0, 3'd7, 2'd0, 0, 16'h0));
    req0 = 1'b0;
    #2 reset_n = 1'b1;
    nres = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (ack0 || ack1 || busy) nres++;
    end
    chk("t1_no_ack", 48'(nres), 48'd0);

    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    io_ready = 8'hFF;
    run_txn("rst_arb", 0, 8'h00, ack_e, we_cnt, who);
    chk("rst_arb_who", 48'(who), 48'd0);
    chk("rst_arb_lat", 48'(ack_e), 48'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
